tx_flusher_gen: RTL and testbench
=================================

# tx_flusher_gen

Parametrised next-generation TX flusher between the TX framing logic and the lane swizzler. It passes data frames through with zero latency and escapes literal ESC frames as ESC,ESC. On idle timeout or an explicit request it emits an ESC followed by a programmable burst of FLUSH frames. This drains the swizzler and keeps sync characters separated in the RX FIFO. Adds runtime thresholds, forced flush and saturating statistics.

## Interface
- DATA_W, 192, frame width in bits
- CNT_W, 4, width of idle counter and cfg_idle_th
- FLEN_W, 3, width of cfg_flush_len and the flush burst counter
- STAT_W, 16, width of the statistics counters
- clk  in  1  clock; the block has one clock
- reset  in  1  synchronous, active-high reset
- in_enable  in  1  advance enable; low = freeze
- in_txdata  in  DATA_W  frame from upper
- in_txdata_valid  in  1  frame valid
- out_idle  out  1  ready to upper; a frame is consumed when valid && out_idle
- out_txdata  out  DATA_W  frame to lower
- out_txdata_valid  out  1  frame valid to lower
- in_idle  in  1  ready from lower
- cfg_idle_th  in  CNT_W  idle threshold; 0 disables auto-flush
- cfg_flush_len  in  FLEN_W  FLUSH frames per flush; 0 is treated as 1
- flush_req  in  1  single-cycle request for a flush, e.g. on a lane status change
- stat_flush_cnt  out  STAT_W  flushes started, saturating
- stat_esc_cnt  out  STAT_W  literal-ESC escapes, saturating

## Operation
- States: NORMAL, SEND_ESC, SEND_FLUSH.
- Registers: state, idle_cnt, flush_cnt, flush_pend, and both stat counters. All reset to NORMAL or 0.
- Data, valid and ready paths are combinational. By default out_txdata=in_txdata, out_txdata_valid=in_txdata_valid and out_idle=in_idle.
- **NORMAL, priority order:**
  1. (flush_pend || flush_req) && in_idle: emit ESC_PACK valid with out_idle=0, so upstream holds its frame. Set flush_cnt=max(cfg_flush_len,1), clear flush_pend, increment stat_flush_cnt, go to SEND_FLUSH.
  2. in_idle && !valid && cfg_idle_th!=0 && idle_cnt==cfg_idle_th: same actions as item 1. Auto flush.
  3. in_idle && valid && in_txdata==ESC_PACK: emit ESC valid and consume the frame (out_idle=1). Increment stat_esc_cnt and go to SEND_ESC.
  4. in_idle && !valid: idle_cnt+1, saturating at all-ones.
  5. Otherwise: idle_cnt=0.
- **SEND_ESC:** out_txdata=ESC_PACK, out_idle=0, out_txdata_valid=in_idle. When in_idle, go to NORMAL.
- **SEND_FLUSH:** out_txdata=FLUSH_PACK, out_idle=0, out_txdata_valid=in_idle. Each cycle with in_idle decrements flush_cnt. When flush_cnt reaches 1 and in_idle, go to NORMAL.
- idle_cnt is cleared on every transition out of NORMAL and held at 0 outside NORMAL.
- **flush_req latching:**
  - A flush_req in NORMAL that does not start a flush that cycle sets flush_pend.
  - A flush_req in SEND_ESC sets flush_pend.
  - A flush_req in SEND_FLUSH, or in the cycle an ESC for a flush is emitted, is absorbed.
- **in_enable=0:** out_txdata_valid=0 and out_idle=0. state, idle_cnt, flush_cnt and stats hold. flush_req still sets flush_pend.
- **Invariant:** out_txdata_valid implies in_idle && in_enable.
- **Receiver semantics:** ESC,ESC decodes as a literal ESC frame. ESC,FLUSH starts a discard burst. FLUSH_PACK data is never escaped.

## Timing
- Zero-cycle latency on data, valid and ready. There are no output registers on the frame path.
- Reset outputs with inputs idle: out_txdata_valid=0, out_idle=in_idle, stats=0.
- Auto flush with cfg_idle_th=N: ESC on the (N+1)th consecutive idle cycle, then FLUSH frames from the next ready cycle onward.
- Stalls (in_idle=0) in SEND_ESC or SEND_FLUSH hold the state and emit nothing.
- Reset asserted mid-sequence abandons the remaining ESC/FLUSH frames. It also clears flush_pend.
- cfg_flush_len is sampled only when the ESC is emitted; later changes do not affect the burst in progress.
- Stat counters update on the clock edge after the triggering cycle and stick at all-ones.

## Structure
- Shared package pcs_tx_pkg holds ESC_PACK, FLUSH_PACK (DATA_W-wide constants) and the state encoding. The RX deflusher uses the same package.
- One sub-module, pcs_sat_counter, is parametrised by width with inc and clear inputs. It is instantiated twice, for the two stats.

## Test plan
- **Idle timeout:** cfg_idle_th=7, cfg_flush_len=1, valid=0, in_idle=1 → ESC on cycle 8, FLUSH on cycle 9, NORMAL on cycle 10; stat_flush_cnt=1.
- **Literal ESC:** ESC_PACK sent with valid=1 → out ESC, ESC on consecutive cycles; out_idle=0 in the second cycle; stat_esc_cnt=1.
- **Forced flush with stalls:** flush_req while valid data is pending, cfg_flush_len=3, with in_idle=0 for 2 cycles mid-burst → ESC, then 3 FLUSH frames with no output during the stall. Upstream data is emitted unchanged afterwards.
- **Simultaneous requests:** flush_req during SEND_ESC → ESC,ESC then ESC,FLUSH. flush_req during SEND_FLUSH → no extra flush.
- **in_enable gating:** in_enable=0 for 5 cycles mid-burst → no valid output, state holds, and the burst resumes unchanged.
- **Reset and saturation:** reset during SEND_FLUSH → NORMAL next cycle with all counters 0. Running 70000 flushes with STAT_W=16 → stat_flush_cnt=65535.

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// Shared TX/RX PCS definitions: escape/flush code words and flusher state encoding.
// The RX deflusher decodes the same ESC_PACK/FLUSH_PACK words.
package pcs_tx_pkg;

    localparam int PACK_W = 192;

    localparam logic [PACK_W-1:0] ESC_PACK   = {24{8'h5C}};
    localparam logic [PACK_W-1:0] FLUSH_PACK = {24{8'hF1}};

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        SEND_ESC   = 2'd1,
        SEND_FLUSH = 2'd2
    } tx_flush_state_t;

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared by reset or clear.
module pcs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tx_flusher_gen.sv
// TX flusher: zero-latency pass-through that escapes literal ESC frames and inserts
// ESC + FLUSH bursts on idle timeout or on request, with saturating statistics.
module tx_flusher_gen
    import pcs_tx_pkg::*;
#(
    parameter int DATA_W = 192,
    parameter int CNT_W  = 4,
    parameter int FLEN_W = 3,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_enable,
    input  logic [DATA_W-1:0] in_txdata,
    input  logic              in_txdata_valid,
    output logic              out_idle,
    output logic [DATA_W-1:0] out_txdata,
    output logic              out_txdata_valid,
    input  logic              in_idle,
    input  logic [CNT_W-1:0]  cfg_idle_th,
    input  logic [FLEN_W-1:0] cfg_flush_len,
    input  logic              flush_req,
    output logic [STAT_W-1:0] stat_flush_cnt,
    output logic [STAT_W-1:0] stat_esc_cnt
);

    localparam logic [DATA_W-1:0] ESC_W   = DATA_W'(ESC_PACK);
    localparam logic [DATA_W-1:0] FLUSH_W = DATA_W'(FLUSH_PACK);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A programmed length of zero still produces one FLUSH frame.
    function automatic logic [FLEN_W-1:0] eff_len(input logic [FLEN_W-1:0] l);
        return (l == '0) ? FLEN_W'(1) : l;
    endfunction

    tx_flush_state_t   state, state_nxt;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_nxt;
    logic [FLEN_W-1:0] flush_cnt, flush_cnt_nxt;
    logic              flush_pend, flush_pend_nxt;
    logic              flush_inc, esc_inc;
    logic              auto_hit;

    assign auto_hit = !in_txdata_valid && (cfg_idle_th != '0) && (idle_cnt == cfg_idle_th);

    always_comb begin
        state_nxt        = state;
        idle_cnt_nxt     = idle_cnt;
        flush_cnt_nxt    = flush_cnt;
        flush_pend_nxt   = flush_pend;
        flush_inc        = 1'b0;
        esc_inc          = 1'b0;
        out_txdata       = in_txdata;
        out_txdata_valid = in_txdata_valid;
        out_idle         = in_idle;

        if (!in_enable) begin
            out_txdata_valid = 1'b0;
            out_idle         = 1'b0;
            flush_pend_nxt   = flush_pend || flush_req;
        end else begin
            unique case (state)
                NORMAL: begin
                    if (in_idle && (flush_pend || flush_req || auto_hit)) begin
                        // Upstream is held off while the ESC that opens the burst goes out.
                        out_txdata       = ESC_W;
                        out_txdata_valid = 1'b1;
                        out_idle         = 1'b0;
                        flush_cnt_nxt    = eff_len(cfg_flush_len);
                        flush_pend_nxt   = 1'b0;
                        flush_inc        = 1'b1;
                        idle_cnt_nxt     = '0;
                        state_nxt        = SEND_FLUSH;
                    end else if (in_idle && in_txdata_valid && (in_txdata == ESC_W)) begin
                        out_txdata       = ESC_W;
                        out_txdata_valid = 1'b1;
                        esc_inc          = 1'b1;
                        idle_cnt_nxt     = '0;
                        flush_pend_nxt   = flush_pend || flush_req;
                        state_nxt        = SEND_ESC;
                    end else if (in_idle && !in_txdata_valid) begin
                        idle_cnt_nxt     = sat_inc(idle_cnt);
                        flush_pend_nxt   = flush_pend || flush_req;
                    end else begin
                        idle_cnt_nxt     = '0;
                        flush_pend_nxt   = flush_pend || flush_req;
                    end
                end
                SEND_ESC: begin
                    out_txdata       = ESC_W;
                    out_txdata_valid = in_idle;
                    out_idle         = 1'b0;
                    idle_cnt_nxt     = '0;
                    flush_pend_nxt   = flush_pend || flush_req;
                    if (in_idle) begin
                        state_nxt = NORMAL;
                    end
                end
                SEND_FLUSH: begin
                    // Requests arriving mid-burst are absorbed by the burst in progress.
                    out_txdata       = FLUSH_W;
                    out_txdata_valid = in_idle;
                    out_idle         = 1'b0;
                    idle_cnt_nxt     = '0;
                    if (in_idle) begin
                        flush_cnt_nxt = flush_cnt - FLEN_W'(1);
                        if (flush_cnt == FLEN_W'(1)) begin
                            state_nxt = NORMAL;
                        end
                    end
                end
                default: begin
                    state_nxt    = NORMAL;
                    idle_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            idle_cnt   <= '0;
            flush_cnt  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_cnt_nxt;
            flush_cnt  <= flush_cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    pcs_sat_counter #(.W(STAT_W)) u_stat_flush (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (flush_inc),
        .cnt   (stat_flush_cnt)
    );

    pcs_sat_counter #(.W(STAT_W)) u_stat_esc (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (esc_inc),
        .cnt   (stat_esc_cnt)
    );

endmodule

// File: tb/tb_tx_flusher_gen.sv
// Bench for tx_flusher_gen: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tx_flusher_gen;
    import pcs_tx_pkg::*;

    localparam int DATA_W  = 192;
    localparam int CNT_W   = 4;
    localparam int FLEN_W  = 3;
    localparam int STAT_W  = 16;
    localparam int SMALL_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, in_enable, in_txdata_valid, in_idle, flush_req;
    logic [DATA_W-1:0]  in_txdata;
    logic [CNT_W-1:0]   cfg_idle_th;
    logic [FLEN_W-1:0]  cfg_flush_len;
    logic               out_idle, out_txdata_valid;
    logic [DATA_W-1:0]  out_txdata;
    logic [STAT_W-1:0]  stat_flush_cnt, stat_esc_cnt;
    logic               out_idle_s, out_txdata_valid_s;
    logic [DATA_W-1:0]  out_txdata_s;
    logic [SMALL_W-1:0] stat_flush_cnt_s, stat_esc_cnt_s;

    tx_flusher_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLEN_W(FLEN_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .in_enable(in_enable), .in_txdata(in_txdata),
        .in_txdata_valid(in_txdata_valid), .out_idle(out_idle), .out_txdata(out_txdata),
        .out_txdata_valid(out_txdata_valid), .in_idle(in_idle), .cfg_idle_th(cfg_idle_th),
        .cfg_flush_len(cfg_flush_len), .flush_req(flush_req),
        .stat_flush_cnt(stat_flush_cnt), .stat_esc_cnt(stat_esc_cnt)
    );

    // Narrow-statistics instance on the same stimulus, so saturation is reachable quickly.
    tx_flusher_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLEN_W(FLEN_W), .STAT_W(SMALL_W)) dut_s (
        .clk(clk), .reset(reset), .in_enable(in_enable), .in_txdata(in_txdata),
        .in_txdata_valid(in_txdata_valid), .out_idle(out_idle_s), .out_txdata(out_txdata_s),
        .out_txdata_valid(out_txdata_valid_s), .in_idle(in_idle), .cfg_idle_th(cfg_idle_th),
        .cfg_flush_len(cfg_flush_len), .flush_req(flush_req),
        .stat_flush_cnt(stat_flush_cnt_s), .stat_esc_cnt(stat_esc_cnt_s)
    );

    // Stimulus shadows, applied on the falling edge by step().
    bit                r_rst, r_en, r_idle, r_vld, r_req;
    logic [DATA_W-1:0] r_data;
    int                r_th, r_len;

    // Reference model: frames still owed downstream, idle run length, pending request.
    logic [DATA_W-1:0] owed[$];
    int                m_idle_run;
    bit                m_pend;
    int                m_flushes, m_escs;

    bit                cmp_en;
    int                n_cmp, n_bad;
    bit                cap_valid, cap_idle;
    logic [DATA_W-1:0] cap_data;

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [DATA_W-1:0] e_data;
        bit e_valid, e_idle, auto_f;
        bit a_start, a_esc, a_pop, a_pend, a_inc, a_clr;
        int a_len;

        @(negedge clk);
        reset           = r_rst;
        in_enable       = r_en;
        in_idle         = r_idle;
        in_txdata_valid = r_vld;
        in_txdata       = r_data;
        flush_req       = r_req;
        cfg_idle_th     = CNT_W'(r_th);
        cfg_flush_len   = FLEN_W'(r_len);
        #1;

        e_data = r_data; e_valid = r_vld; e_idle = r_idle;
        a_start = 0; a_esc = 0; a_pop = 0; a_pend = 0; a_inc = 0; a_clr = 0; a_len = 0;
        auto_f = r_idle && !r_vld && (r_th != 0) && (sat(m_idle_run, CNT_W) == r_th);
        if (!r_en) begin
            e_valid = 0; e_idle = 0; a_pend = r_req;
        end else if (owed.size() != 0) begin
            e_data = owed[0]; e_valid = r_idle; e_idle = 0; a_pop = r_idle; a_clr = 1;
            a_pend = r_req && (owed[0] == ESC_PACK);
        end else if (r_idle && (m_pend || r_req || auto_f)) begin
            e_data = ESC_PACK; e_valid = 1; e_idle = 0; a_start = 1;
            a_len = (r_len == 0) ? 1 : r_len;
        end else if (r_idle && r_vld && (r_data == ESC_PACK)) begin
            e_data = ESC_PACK; e_valid = 1; e_idle = 1; a_esc = 1; a_pend = r_req;
        end else if (r_idle && !r_vld) begin
            a_inc = 1; a_pend = r_req;
        end else begin
            a_clr = 1; a_pend = r_req;
        end

        cap_valid = out_txdata_valid;
        cap_idle  = out_idle;
        cap_data  = out_txdata;
        if (cmp_en) begin
            chk_int("out_txdata_valid", int'(out_txdata_valid), int'(e_valid));
            chk_int("out_idle", int'(out_idle), int'(e_idle));
            if (e_valid) chk_data("out_txdata", out_txdata, e_data);
            chk_int("stat_flush_cnt", int'(stat_flush_cnt), sat(m_flushes, STAT_W));
            chk_int("stat_esc_cnt", int'(stat_esc_cnt), sat(m_escs, STAT_W));
            chk_int("stat_flush_cnt_narrow", int'(stat_flush_cnt_s), sat(m_flushes, SMALL_W));
            chk_int("stat_esc_cnt_narrow", int'(stat_esc_cnt_s), sat(m_escs, SMALL_W));
        end

        @(posedge clk);
        if (r_rst) begin
            owed.delete();
            m_idle_run = 0; m_pend = 0; m_flushes = 0; m_escs = 0;
            cmp_en = 1;
        end else begin
            if (a_pop) void'(owed.pop_front());
            if (a_start) begin
                for (int i = 0; i < a_len; i++) owed.push_back(FLUSH_PACK);
                m_pend = 0; m_flushes++; m_idle_run = 0;
            end
            if (a_esc) begin
                owed.push_back(ESC_PACK); m_escs++; m_idle_run = 0;
            end
            if (a_pend) m_pend = 1;
            if (a_inc) m_idle_run++;
            if (a_clr) m_idle_run = 0;
        end
    endtask

    task automatic lit(input string name, input bit v, input bit i, input logic [DATA_W-1:0] d,
                       input bit ev, input bit ei, input logic [DATA_W-1:0] ed);
        chk_int({name, "_valid"}, int'(v), int'(ev));
        chk_int({name, "_idle"}, int'(i), int'(ei));
        if (ev) chk_data({name, "_data"}, d, ed);
    endtask

    bit                tv[1:10], ti[1:10];
    logic [DATA_W-1:0] td[1:10];
    logic [DATA_W-1:0] dpay;

    initial begin
        n_cmp = 0; n_bad = 0; cmp_en = 0;
        m_idle_run = 0; m_pend = 0; m_flushes = 0; m_escs = 0;
        r_rst = 1; r_en = 1; r_idle = 1; r_vld = 0; r_data = '0; r_req = 0; r_th = 0; r_len = 1;
        step(); step();

        // Idle timeout, threshold 7, one FLUSH frame.
        r_rst = 0; r_th = 7; r_len = 1;
        for (int c = 1; c <= 10; c++) begin
            step();
            tv[c] = cap_valid; ti[c] = cap_idle; td[c] = cap_data;
        end
        lit("reset_out", tv[1], ti[1], td[1], 0, 1, '0);
        lit("timeout_c7", tv[7], ti[7], td[7], 0, 1, '0);
        lit("timeout_esc", tv[8], ti[8], td[8], 1, 0, ESC_PACK);
        lit("timeout_flush", tv[9], ti[9], td[9], 1, 0, FLUSH_PACK);
        lit("timeout_back", tv[10], ti[10], td[10], 0, 1, '0);
        #1 chk_int("timeout_stat", int'(stat_flush_cnt), 1);

        // Literal ESC escaping.
        r_th = 0; r_vld = 1; r_data = ESC_PACK;
        step(); lit("lit_esc1", cap_valid, cap_idle, cap_data, 1, 1, ESC_PACK);
        r_vld = 0;
        step(); lit("lit_esc2", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        #1 chk_int("lit_esc_stat", int'(stat_esc_cnt), 1);

        // Forced flush with pending data and a two-cycle stall mid-burst.
        dpay = rnd_data();
        r_len = 3; r_vld = 1; r_data = dpay; r_req = 1;
        step(); lit("forced_esc", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        r_req = 0;
        step(); lit("forced_f1", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        r_idle = 0;
        step(); lit("forced_stall1", cap_valid, cap_idle, cap_data, 0, 0, '0);
        step(); lit("forced_stall2", cap_valid, cap_idle, cap_data, 0, 0, '0);
        r_idle = 1;
        step(); lit("forced_f2", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        step(); lit("forced_f3", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        step(); lit("forced_data", cap_valid, cap_idle, cap_data, 1, 1, dpay);
        r_vld = 0;

        // Request during SEND_ESC becomes a pending flush; request during SEND_FLUSH is absorbed.
        r_len = 1; r_vld = 1; r_data = ESC_PACK;
        step(); lit("sim_esc1", cap_valid, cap_idle, cap_data, 1, 1, ESC_PACK);
        r_vld = 0; r_req = 1;
        step(); lit("sim_esc2", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        r_req = 0;
        step(); lit("sim_pend_esc", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        step(); lit("sim_pend_flush", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        r_len = 2; r_req = 1;
        step(); lit("abs_esc", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        step(); lit("abs_f1", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        r_req = 0;
        step(); lit("abs_f2", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        step(); lit("abs_none", cap_valid, cap_idle, cap_data, 0, 1, '0);

        // Enable gating mid-burst.
        r_req = 1;
        step(); lit("en_esc", cap_valid, cap_idle, cap_data, 1, 0, ESC_PACK);
        r_req = 0;
        step(); lit("en_f1", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        r_en = 0;
        for (int c = 0; c < 5; c++) begin
            step(); lit("en_off", cap_valid, cap_idle, cap_data, 0, 0, '0);
        end
        r_en = 1;
        step(); lit("en_f2", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        step(); lit("en_back", cap_valid, cap_idle, cap_data, 0, 1, '0);
        #1 chk_int("en_stat", int'(stat_flush_cnt), 5);

        // Reset in the middle of a burst.
        r_len = 4; r_req = 1;
        step(); r_req = 0;
        step();
        r_rst = 1;
        step(); lit("rst_flush", cap_valid, cap_idle, cap_data, 1, 0, FLUSH_PACK);
        #1 chk_int("rst_stat_flush", int'(stat_flush_cnt), 0);
        chk_int("rst_stat_esc", int'(stat_esc_cnt), 0);
        r_rst = 0;
        step(); lit("rst_normal", cap_valid, cap_idle, cap_data, 0, 1, '0);

        // Back-to-back requests: 30 flushes, narrow statistics saturate.
        r_len = 1; r_req = 1;
        for (int c = 0; c < 60; c++) step();
        r_req = 0;
        #1 chk_int("sat_wide", int'(stat_flush_cnt), 30);
        chk_int("sat_narrow", int'(stat_flush_cnt_s), 15);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            r_rst  = ($urandom_range(0, 499) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_idle = ($urandom_range(0, 3) != 0);
            r_vld  = ($urandom_range(0, 1) == 1);
            r_req  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 19))
                0, 1, 2, 3: r_data = ESC_PACK;
                4:          r_data = FLUSH_PACK;
                default:    r_data = rnd_data();
            endcase
            if ($urandom_range(0, 99) == 0) r_th = $urandom_range(0, 15);
            if ($urandom_range(0, 49) == 0) r_len = $urandom_range(0, 7);
            if ($urandom_range(0, 29) == 0) r_vld = 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
